fp32_add_norm_round: RTL and testbench



---
 rtl/fp32_add_norm_round.sv | 146 ++++++++++++++
 tb/tb_fp32_add_norm_round.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fp32_add_norm_round.sv
// Normalize / round-to-nearest-even / pack stage of the single-precision adder.
// Two registered stages (normalize, round+pack) with valid/ready on both sides.
module fp32_add_norm_round #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic [FRAC_W+4:0]         in_mant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     result,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      inexact
);

  // Normalized mantissa: hidden, fraction, guard, round, sticky.
  localparam int unsigned MW  = FRAC_W + 4;
  localparam int unsigned EW  = EXP_W + 2;
  localparam int unsigned LzW = $clog2(MW);
  localparam logic [EW-1:0] ExpMax = EW'((1 << EXP_W) - 1);

  logic                 s1_valid_q, s1_sign_q, s1_zero_q, s1_flush_q;
  logic [EW-1:0]        s1_exp_q;
  logic [MW-1:0]        s1_mant_q;
  logic                 out_valid_q, overflow_q, underflow_q, inexact_q;
  logic [EXP_W+FRAC_W:0] result_q;

  logic s1_adv, s2_adv;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: leading-zero count and normalization shift.
  logic [LzW-1:0] lz;
  logic           lz_found;
  logic [MW-1:0]  norm_mant;
  logic [EW-1:0]  exp_ext, norm_exp;
  logic           norm_zero, norm_flush;

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!lz_found && in_mant[i]) begin
        lz       = LzW'(MW - 1 - i);
        lz_found = 1'b1;
      end
    end
    exp_ext   = {2'b00, in_exp};
    norm_zero = (in_mant == '0);
    if (in_mant[MW]) begin
      norm_mant = {in_mant[MW:2], |in_mant[1:0]};
      norm_exp  = exp_ext + EW'(1);
    end else begin
      norm_mant = in_mant[MW-1:0] << lz;
      norm_exp  = exp_ext - EW'(lz);
    end
    // Non-positive exponent (sign bit or zero) has no representation without denormals.
    norm_flush = !norm_zero && (norm_exp[EW-1] || norm_exp == '0 || in_exp == '0);
  end

  // Stage 2: round to nearest even and pack.
  logic [FRAC_W-1:0]     frac;
  logic                  g_bit, r_bit, s_bit, round_up;
  logic [FRAC_W:0]       frac_rnd;
  logic [EW-1:0]         exp_rnd;
  logic [EXP_W+FRAC_W:0] result_d;
  logic                  overflow_d, underflow_d, inexact_d;

  always_comb begin
    frac     = s1_mant_q[MW-2:3];
    g_bit    = s1_mant_q[2];
    r_bit    = s1_mant_q[1];
    s_bit    = s1_mant_q[0];
    round_up = g_bit && (r_bit || s_bit || frac[0]);
    frac_rnd = {1'b0, frac} + (FRAC_W + 1)'(round_up);
    exp_rnd  = s1_exp_q + EW'(frac_rnd[FRAC_W]);

    result_d    = {s1_sign_q, exp_rnd[EXP_W-1:0], frac_rnd[FRAC_W-1:0]};
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    inexact_d   = g_bit | r_bit | s_bit;
    if (s1_zero_q) begin
      result_d  = '0;
      inexact_d = 1'b0;
    end else if (s1_flush_q) begin
      result_d    = {s1_sign_q, {(EXP_W + FRAC_W){1'b0}}};
      underflow_d = 1'b1;
      inexact_d   = 1'b1;
    end else if (exp_rnd >= ExpMax) begin
      result_d   = {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      overflow_d = 1'b1;
      inexact_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_flush_q  <= 1'b0;
      s1_exp_q    <= '0;
      s1_mant_q   <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_sign_q  <= in_sign & ~norm_zero;
          s1_zero_q  <= norm_zero;
          s1_flush_q <= norm_flush;
          s1_exp_q   <= norm_exp;
          s1_mant_q  <= norm_mant;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          result_q    <= result_d;
          overflow_q  <= overflow_d;
          underflow_q <= underflow_d;
          inexact_q   <= inexact_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp32_add_norm_round.sv
// Directed bench for fp32_add_norm_round: hand-computed vectors, backpressure and mid-flight reset.
module tb_fp32_add_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        overflow, underflow, inexact;

  int n_cmp = 0;
  int n_err = 0;

  fp32_add_norm_round dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sign  (in_sign),
    .in_exp   (in_exp),
    .in_mant  (in_mant),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow),
    .underflow(underflow),
    .inexact  (inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [27:0] m);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
  endtask

  // Called at posedge+1 with out_ready=1; checks 2-cycle latency and the packed result/flags.
  task automatic send_check(input string tag, input logic s, input logic [7:0] e,
                            input logic [27:0] m, input logic [31:0] exp_res,
                            input logic [2:0] exp_flags);
    drive(s, e, m);
    chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "/early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "/valid"}, 32'(out_valid), 32'd1);
    chk({tag, "/result"}, result, exp_res);
    chk({tag, "/flags"}, 32'({overflow, underflow, inexact}), 32'(exp_flags));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/result", result, 32'h0);
    chk("rst/flags", 32'({overflow, underflow, inexact}), 32'd0);
    chk("rst/in_ready", 32'(in_ready), 32'd1);

    // flags order: {overflow, underflow, inexact}
    send_check("one_plus_one", 1'b0, 8'd127, 28'h8000000, 32'h40000000, 3'b000);
    send_check("cancel_lz23", 1'b0, 8'd127, 28'h0000008, 32'h34000000, 3'b000);
    send_check("tie_even", 1'b0, 8'd127, 28'h4000004, 32'h3F800000, 3'b001);
    send_check("tie_odd", 1'b0, 8'd127, 28'h400000C, 32'h3F800002, 3'b001);
    send_check("overflow", 1'b0, 8'd254, 28'h8000000, 32'h7F800000, 3'b101);
    send_check("underflow", 1'b0, 8'd3, 28'h0000008, 32'h00000000, 3'b011);
    send_check("zero_sum", 1'b1, 8'd100, 28'h0000000, 32'h00000000, 3'b000);
    send_check("carry_tie_odd", 1'b0, 8'd127, 28'h8000018, 32'h40000002, 3'b001);
    send_check("round_carry", 1'b1, 8'd127, 28'h7FFFFFC, 32'hC0000000, 3'b001);
    send_check("round_ovf", 1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000, 3'b101);
    send_check("exp0_flush", 1'b1, 8'd0, 28'h4000000, 32'h80000000, 3'b011);
    @(posedge clk); #1;
    chk("idle/out_valid", 32'(out_valid), 32'd0);

    // Backpressure: three back-to-back sums with the sink stalled.
    out_ready = 1'b0;
    drive(1'b0, 8'd127, 28'h8000000);
    chk("bp/ready_a", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 8'd127, 28'h400000C);
    chk("bp/ready_b", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 8'd127, 28'h0000008);
    chk("bp/ready_c_low", 32'(in_ready), 32'd0);
    chk("bp/valid_a", 32'(out_valid), 32'd1);
    chk("bp/result_a", result, 32'h40000000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp/hold_valid", 32'(out_valid), 32'd1);
      chk("bp/hold_result", result, 32'h40000000);
      chk("bp/hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp/ready_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp/valid_b", 32'(out_valid), 32'd1);
    chk("bp/result_b", result, 32'h3F800002);
    @(posedge clk); #1;
    chk("bp/valid_c", 32'(out_valid), 32'd1);
    chk("bp/result_c", result, 32'h34000000);
    @(posedge clk); #1;
    chk("bp/drained", 32'(out_valid), 32'd0);

    // Reset with both stages occupied.
    drive(1'b0, 8'd127, 28'h8000000);
    @(posedge clk); #1;
    drive(1'b0, 8'd127, 28'h4000004);
    @(posedge clk); #1;
    chk("rstmid/s2_full", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstmid/out_valid", 32'(out_valid), 32'd0);
    chk("rstmid/in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("rstmid/no_leak", 32'(out_valid), 32'd0);
    send_check("post_rst", 1'b1, 8'd127, 28'h8000000, 32'hC0000000, 3'b000);
    @(posedge clk); #1;
    chk("post_rst/single", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
